// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: op encodings, FSM states
// and the step-counter width helper.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_MADD  = 3'd6,
        MDU_MSUB  = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } mdu_state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring-division step
// on a shared 2*WIDTH accumulator.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     opnd,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] diff;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {remainder, remaining dividend bits / quotient bits}.
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        partial = acc[2*WIDTH-1:WIDTH-1];
        diff    = partial[WIDTH-1:0] - opnd;
        if (is_div) begin
            if (partial >= {1'b0, opnd})
                acc_next = {diff, acc[WIDTH-2:0], 1'b1};
            else
                acc_next = {partial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Define MDU_MADD_EN to enable MADD/MSUB (ops 6/7); otherwise they are no-ops.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = cnt_width(WIDTH);

    mdu_state_t         state;
    mdu_op_t            op_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_orig;
    logic               neg_q;
    logic               neg_r;
    logic               div0;

    mdu_op_t            op_in;
    logic               signed_in;
    logic               div_in;
    logic               long_in;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               is_div_q;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    assign stall_req = start | busy;

    always_comb begin
        op_in     = mdu_op_t'(op);
        div_in    = (op_in == MDU_DIV) || (op_in == MDU_DIVU);
`ifdef MDU_MADD_EN
        signed_in = (op_in == MDU_MULT) || (op_in == MDU_DIV) ||
                    (op_in == MDU_MADD) || (op_in == MDU_MSUB);
        long_in   = (op_in != MDU_MTHI) && (op_in != MDU_MTLO);
`else
        signed_in = (op_in == MDU_MULT) || (op_in == MDU_DIV);
        long_in   = (op_in == MDU_MULT) || (op_in == MDU_MULTU) || div_in;
`endif
        // Unsigned WIDTH-bit magnitude holds |most-negative| without overflow.
        mag_a     = (signed_in && A[WIDTH-1]) ? -A : A;
        mag_b     = (signed_in && B[WIDTH-1]) ? -B : B;
        is_div_q  = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
    end

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div_q),
        .acc      (acc),
        .opnd     (opnd),
        .acc_next (acc_next)
    );

    always_comb begin
        prod    = neg_q ? -acc : acc;
        mul_res = prod;
`ifdef MDU_MADD_EN
        if (op_q == MDU_MADD)
            mul_res = {HI, LO} + prod;
        else if (op_q == MDU_MSUB)
            mul_res = {HI, LO} - prod;
`endif
        quot = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            op_q   <= MDU_MULT;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            a_orig <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            busy   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (long_in) begin
                            op_q   <= op_in;
                            opnd   <= div_in ? mag_b : mag_a;
                            acc    <= {{WIDTH{1'b0}}, (div_in ? mag_a : mag_b)};
                            a_orig <= A;
                            neg_q  <= signed_in & (A[WIDTH-1] ^ B[WIDTH-1]);
                            neg_r  <= signed_in & A[WIDTH-1];
                            div0   <= div_in && (B == '0);
                            cnt    <= '0;
                            busy   <= 1'b1;
                            state  <= CALC;
                        end else if (op_in == MDU_MTHI) begin
                            HI <= A;
                        end else if (op_in == MDU_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    if (is_div_q) begin
                        if (div0) begin
                            HI <= a_orig;
                            LO <= '1;
                        end else begin
                            HI <= rem;
                            LO <= quot;
                        end
                    end else begin
                        {HI, LO} <= mul_res;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (WIDTH=32): directed scenarios with literal
// expectations plus randomized traffic against a cycle-level behavioural model.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic        stall_req;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    mdu_iter #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .stall_req (stall_req),
        .HI        (HI),
        .LO        (LO)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Architectural result of one op from plain integer arithmetic.
    function automatic logic [63:0] model_result(input logic [2:0] o, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [63:0] hilo);
        longint sa;
        longint sb;
        logic [63:0] q;
        logic [63:0] rm;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = hilo;
        case (o)
            3'd0: r = 64'(sa * sb);
            3'd1: r = {32'b0, a} * {32'b0, b};
            3'd2: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, a};
                else begin
                    q = sa / sb;
                    rm = sa % sb;
                    r = {rm[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
`ifdef MDU_MADD_EN
            3'd6: r = hilo + 64'(sa * sb);
            3'd7: r = hilo - 64'(sa * sb);
`endif
            default: r = hilo;
        endcase
        return r;
    endfunction

    function automatic bit model_long(input logic [2:0] o);
`ifdef MDU_MADD_EN
        return (o != 3'd4) && (o != 3'd5);
`else
        return o <= 3'd3;
`endif
    endfunction

    // Behavioural model: an accepted long op keeps busy for 33 edges, then commits.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    bit          m_busy = 1'b0;
    int          m_left = 0;
    logic [63:0] m_pend = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi = '0;
            m_lo = '0;
            m_busy = 1'b0;
            m_left = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                {m_hi, m_lo} = m_pend;
                m_busy = 1'b0;
            end
        end else if (start) begin
            if (model_long(op)) begin
                m_pend = model_result(op, A, B, {m_hi, m_lo});
                m_left = 33;
                m_busy = 1'b1;
            end else if (op == 3'd4) begin
                m_hi = A;
            end else if (op == 3'd5) begin
                m_lo = A;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_busy", {31'b0, busy}, {31'b0, m_busy});
            chk("model_stall_req", {31'b0, stall_req}, {31'b0, start | m_busy});
            chk("model_HI", HI, m_hi);
            chk("model_LO", LO, m_lo);
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, output int cycles);
        cycles = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            cycles++;
        end
        chk({name, "_idle_timeout"}, {31'b0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            4: return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cyc;
        logic [31:0] h0;
        logic [31:0] l0;

        @(posedge clk); #1;
        chk_en = 1'b1;
        reset = 1'b0;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_HI", HI, 32'd0);
        chk("reset_LO", LO, 32'd0);

        issue(3'd0, 32'hFFFF_FFFD, 32'd7);
        wait_idle("mult", cyc);
        chk("mult_busy_cycles", cyc, 32'd33);
        chk("mult_HI", HI, 32'hFFFF_FFFF);
        chk("mult_LO", LO, 32'hFFFF_FFEB);

        // MULTU followed by DIV held on start so it lands the cycle busy falls.
        @(posedge clk); #1;
        start = 1'b1; op = 3'd1; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        op = 3'd2; A = 32'hFFFF_FFF9; B = 32'd2;
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            cyc++;
        end
        chk("multu_busy_cycles", cyc, 32'd33);
        chk("multu_HI", HI, 32'hFFFF_FFFE);
        chk("multu_LO", LO, 32'h0000_0001);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_accept_busy", {31'b0, busy}, 32'd1);
        wait_idle("div", cyc);
        chk("div_LO", LO, 32'hFFFF_FFFD);
        chk("div_HI", HI, 32'hFFFF_FFFF);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("div_ovf", cyc);
        chk("div_ovf_LO", LO, 32'h8000_0000);
        chk("div_ovf_HI", HI, 32'h0);

        issue(3'd3, 32'd7, 32'd0);
        wait_idle("divu0", cyc);
        chk("divu0_busy_cycles", cyc, 32'd33);
        chk("divu0_LO", LO, 32'hFFFF_FFFF);
        chk("divu0_HI", HI, 32'd7);

        issue(3'd2, 32'hFFFF_FFF0, 32'd0);
        wait_idle("div0_neg", cyc);
        chk("div0_neg_LO", LO, 32'hFFFF_FFFF);
        chk("div0_neg_HI", HI, 32'hFFFF_FFF0);

        issue(3'd0, 32'd5, 32'd6);
        repeat (8) @(posedge clk);
        #1;
        start = 1'b1; op = 3'd4; A = 32'h1234;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("mult_mthi", cyc);
        chk("ignored_mthi_HI", HI, 32'd0);
        chk("ignored_mthi_LO", LO, 32'd30);

        issue(3'd2, 32'd100, 32'd3);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_HI", HI, 32'd0);
        chk("abort_LO", LO, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        issue(3'd5, 32'h0000_ABCD, 32'd0);
        chk("mtlo_LO", LO, 32'h0000_ABCD);
        chk("mtlo_busy", {31'b0, busy}, 32'd0);

`ifdef MDU_MADD_EN
        issue(3'd5, 32'd10, 32'd0);
        issue(3'd4, 32'd0, 32'd0);
        issue(3'd6, 32'd3, 32'd4);
        wait_idle("madd", cyc);
        chk("madd_busy_cycles", cyc, 32'd33);
        chk("madd_HI", HI, 32'd0);
        chk("madd_LO", LO, 32'd22);
        issue(3'd7, 32'd5, 32'd5);
        wait_idle("msub", cyc);
        chk("msub_HI", HI, 32'hFFFF_FFFF);
        chk("msub_LO", LO, 32'hFFFF_FFFD);
`else
        h0 = HI;
        l0 = LO;
        issue(3'd6, 32'd3, 32'd4);
        chk("op6_busy", {31'b0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("op6_HI", HI, h0);
        chk("op6_LO", LO, l0);
        chk("op6_LO_lit", LO, 32'h0000_ABCD);
`endif

        for (int i = 0; i < 2500; i++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 2) == 0);
            op    = 3'($urandom_range(0, 7));
            A     = pick();
            B     = pick();
            reset = ($urandom_range(0, 599) == 0);
        end
        @(posedge clk); #1;
        start = 1'b0;
        reset = 1'b0;
        wait_idle("random_drain", cyc);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
